// File: rtl/frl_pkg.sv
// Shared definitions for the free register list: sizes, PID/pointer types
// and the reset contents of the free list.
package frl_pkg;

  localparam int FRL_WIDTH     = 7;
  localparam int FRL_DEPTH     = 128;
  localparam int FRL_PTR_WIDTH = FRL_WIDTH + 1;
  localparam int NUM_ARCH_REGS = 32;

  // Index 0 is the MSB; for pointers bit 0 is the wrap (lap) bit.
  typedef logic [0:FRL_WIDTH-1]     pid_t;
  typedef logic [0:FRL_PTR_WIDTH-1] frl_ptr_t;

  // Tail after reset: every non-architectural PID starts out free.
  localparam frl_ptr_t RESET_WR_PTR = frl_ptr_t'(FRL_DEPTH - NUM_ARCH_REGS);

  // Reset image: slot k holds PID k+NUM_ARCH_REGS.
  // Slots past the free region are never read before being written, so they are cleared.
  function automatic pid_t reset_pid(input int k);
    return (k < FRL_DEPTH - NUM_ARCH_REGS) ? pid_t'(k + NUM_ARCH_REGS) : '0;
  endfunction

endpackage

// File: rtl/free_reg_list.sv
// Free register list: a circular FIFO of free physical register IDs.
// The dispatch unit pops from the head, and the ROB pushes freed PIDs at the tail.
// The checkpoint/flush controller can rewind the head pointer.
// Optional macro FRL_HEAD_PTR_OUT_EN exposes the head pointer for checkpointing.
module free_reg_list
  import frl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     du_dispatch_pid,
  output logic [0:FRL_WIDTH-1]     frl_pid_out,
  output logic                     frl_empty,
  input  logic                     rob_return_pid,
  input  logic [0:FRL_WIDTH-1]     rob_pid_in,
  input  logic                     cfc_flush_frl,
`ifdef FRL_HEAD_PTR_OUT_EN
  input  logic [0:FRL_PTR_WIDTH-1] cfc_flush_frl_value,
  output logic [0:FRL_PTR_WIDTH-1] frl_head_ptr
`else
  input  logic [0:FRL_PTR_WIDTH-1] cfc_flush_frl_value
`endif
);

  pid_t     storage [FRL_DEPTH];
  frl_ptr_t rd_ptr;
  frl_ptr_t wr_ptr;
  pid_t     rd_idx;
  pid_t     wr_idx;
  logic     full;
  logic     do_pop;
  logic     do_push;

  // The low pointer bits address the storage. The wrap bit tells full from empty.
  assign rd_idx    = rd_ptr[1:FRL_PTR_WIDTH-1];
  assign wr_idx    = wr_ptr[1:FRL_PTR_WIDTH-1];
  assign frl_empty = (rd_ptr == wr_ptr);
  assign full      = (rd_ptr[0] != wr_ptr[0]) && (rd_idx == wr_idx);

  // Empty and full come from the pre-edge pointers, so a pop and a push in the same cycle both take effect.
  assign do_pop  = du_dispatch_pid && !frl_empty;
  assign do_push = rob_return_pid && !full;

  // The head PID is read straight from the flop array, with no added latency.
  assign frl_pid_out = storage[rd_idx];

`ifdef FRL_HEAD_PTR_OUT_EN
  assign frl_head_ptr = rd_ptr;
`endif

  // Head/tail pointers; flush rewinds the head and wins over a same-cycle pop
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= RESET_WR_PTR;
    end else begin
      if (cfc_flush_frl)
        rd_ptr <= cfc_flush_frl_value;
      else if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // PID storage; reset reloads the initial free list, pushes write at the tail
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < FRL_DEPTH; k++)
        storage[k] <= reset_pid(k);
    end else if (do_push) begin
      storage[wr_idx] <= rob_pid_in;
    end
  end

endmodule

// File: tb/tb_free_reg_list.sv
// Directed testbench for free_reg_list: reset image, drain, refill to full,
// flush sweep, flush/pop/push collision and mid-stream reset.
module tb_free_reg_list;
  import frl_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     du_dispatch_pid;
  logic [0:FRL_WIDTH-1]     frl_pid_out;
  logic                     frl_empty;
  logic                     rob_return_pid;
  logic [0:FRL_WIDTH-1]     rob_pid_in;
  logic                     cfc_flush_frl;
  logic [0:FRL_PTR_WIDTH-1] cfc_flush_frl_value;
`ifdef FRL_HEAD_PTR_OUT_EN
  logic [0:FRL_PTR_WIDTH-1] frl_head_ptr;
`endif

  int n_total = 0;
  int n_pass  = 0;

  free_reg_list dut (
    .clk                 (clk),
    .reset               (reset),
    .du_dispatch_pid     (du_dispatch_pid),
    .frl_pid_out         (frl_pid_out),
    .frl_empty           (frl_empty),
    .rob_return_pid      (rob_return_pid),
    .rob_pid_in          (rob_pid_in),
    .cfc_flush_frl       (cfc_flush_frl),
`ifdef FRL_HEAD_PTR_OUT_EN
    .cfc_flush_frl_value (cfc_flush_frl_value),
    .frl_head_ptr        (frl_head_ptr)
`else
    .cfc_flush_frl_value (cfc_flush_frl_value)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; du_dispatch_pid = 1'b0; rob_return_pid = 1'b0;
    rob_pid_in = '0; cfc_flush_frl = 1'b0; cfc_flush_frl_value = '0;
    #1;

    // Reset for 3 cycles
    repeat (3) step();
    reset = 1'b0;
    check("rst_empty", 32'(frl_empty), 0);
    check("rst_pid", 32'(frl_pid_out), 32);
    check("rst_rd", 32'(dut.rd_ptr), 0);
    check("rst_wr", 32'(dut.wr_ptr), 96);
`ifdef FRL_HEAD_PTR_OUT_EN
    check("rst_head", 32'(frl_head_ptr), 0);
`endif

    // Hold dispatch for 133 cycles: PIDs 32..127 come out in order, then the list is empty and the head holds.
    du_dispatch_pid = 1'b1;
    for (int i = 0; i < 133; i++) begin
      if (i < 96) begin
        check("drain_empty", 32'(frl_empty), 0);
        check("drain_pid", 32'(frl_pid_out), 32'(32 + i));
      end else begin
        check("drain_empty_hi", 32'(frl_empty), 1);
      end
      step();
    end
    du_dispatch_pid = 1'b0;
    check("drain_rd_hold", 32'(dut.rd_ptr), 96);

    // Return PIDs 0..127 with dispatch low; the list fills up completely.
    rob_return_pid = 1'b1;
    for (int p = 0; p < 128; p++) begin
      rob_pid_in = 7'(p);
      step();
      if (p == 0) check("fill_empty_fall", 32'(frl_empty), 0);
    end
    check("fill_wr_full", 32'(dut.wr_ptr), 224);
    rob_pid_in = 7'd99;
    step();                       // 129th push must be ignored
    rob_return_pid = 1'b0;
    check("push_full_wr", 32'(dut.wr_ptr), 224);
    check("push_full_pid", 32'(frl_pid_out), 0);
    check("full_not_empty", 32'(frl_empty), 0);

    // Flush sweep: storage[k] now holds (k+32) mod 128, and wr_ptr=224
    cfc_flush_frl = 1'b1;
    for (int v = 0; v < 256; v++) begin
      cfc_flush_frl_value = 8'(v);
      step();
      check("flush_rd", 32'(dut.rd_ptr), 32'(v));
      check("flush_pid", 32'(frl_pid_out), 32'((v + 32) % 128));
      check("flush_empty", 32'(frl_empty), (v == 224) ? 32'd1 : 32'd0);
    end

    // Flush, pop and push in the same cycle. The flush wins over the pop, and the push lands at slot 96.
    cfc_flush_frl_value = 8'd10;
    du_dispatch_pid = 1'b1; rob_return_pid = 1'b1; rob_pid_in = 7'd5;
    step();
    cfc_flush_frl = 1'b0; du_dispatch_pid = 1'b0; rob_return_pid = 1'b0;
    check("coll_rd", 32'(dut.rd_ptr), 10);
    check("coll_wr", 32'(dut.wr_ptr), 225);
    check("coll_pid", 32'(frl_pid_out), 42);
    cfc_flush_frl = 1'b1; cfc_flush_frl_value = 8'd96;
    step();
    cfc_flush_frl = 1'b0;
    check("coll_push_landed", 32'(frl_pid_out), 5);
    check("coll_not_empty", 32'(frl_empty), 0);

    // Reset mid-stream after 40 pops
    reset = 1'b1; step(); reset = 1'b0;
    du_dispatch_pid = 1'b1;
    repeat (40) step();
    du_dispatch_pid = 1'b0;
    check("mid_pid40", 32'(frl_pid_out), 72);
    reset = 1'b1; du_dispatch_pid = 1'b1;
    step();
    reset = 1'b0; du_dispatch_pid = 1'b0;
    check("mid_rst_rd", 32'(dut.rd_ptr), 0);
    check("mid_rst_wr", 32'(dut.wr_ptr), 96);
    check("mid_rst_pid", 32'(frl_pid_out), 32);
    check("mid_rst_empty", 32'(frl_empty), 0);
    du_dispatch_pid = 1'b1;
    step();
    du_dispatch_pid = 1'b0;
    check("mid_rst_pop", 32'(frl_pid_out), 33);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
